// File: rtl/otter_mem_arb.sv
// Two-port arbiter in front of a single-ported data memory (CPU data port 0, loader/debug port 1).
// Define OTTER_MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module otter_mem_arb #(
    parameter int unsigned MEM_SIZE = 65536
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [3:0]  p0_strb,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [3:0]  p1_strb,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        dmem_r_en,
    output logic        dmem_w_en,
    output logic [3:0]  dmem_w_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_w_data,
    input  logic [31:0] dmem_r_data
);

    localparam logic [31:0] MEM_LIMIT = MEM_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant_any;
    logic        winner;
    logic        sel_we;
    logic [3:0]  sel_strb;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oob;

    logic        acc_owner;
    logic        acc_we;
    logic        acc_oob;
    logic [3:0]  acc_strb;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

`ifndef OTTER_MEM_ARB_FIXED_PRIO_EN
    // Points at the port that wins a tie; flips to the loser after every grant.
    logic        rr_ptr;
`endif

    // Gated by rst_n so no grant is offered while reset is held.
    assign grant_any = rst_n && (state == IDLE) && (p0_req || p1_req);

    always_comb begin
`ifdef OTTER_MEM_ARB_FIXED_PRIO_EN
        winner = !p0_req;
`else
        winner = (p0_req && p1_req) ? rr_ptr : p1_req;
`endif
        sel_we    = winner ? p1_we    : p0_we;
        sel_strb  = winner ? p1_strb  : p0_strb;
        sel_addr  = winner ? p1_addr  : p0_addr;
        sel_wdata = winner ? p1_wdata : p0_wdata;
        sel_oob   = winner && (p1_addr >= MEM_LIMIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_owner <= 1'b0;
            acc_we    <= 1'b0;
            acc_oob   <= 1'b0;
            acc_strb  <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
`ifndef OTTER_MEM_ARB_FIXED_PRIO_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (grant_any) begin
                acc_owner <= winner;
                acc_we    <= sel_we;
                acc_oob   <= sel_oob;
                acc_strb  <= sel_strb;
                acc_addr  <= sel_addr;
                acc_wdata <= sel_wdata;
`ifndef OTTER_MEM_ARB_FIXED_PRIO_EN
                rr_ptr    <= ~winner;
`endif
            end
        end
    end

    // Address/data come straight from the capture registers, so they hold between accesses.
    always_comb begin
        p0_gnt      = grant_any && !winner;
        p1_gnt      = grant_any && winner;
        p0_done     = 1'b0;
        p1_done     = 1'b0;
        p1_err      = 1'b0;
        p0_rdata    = '0;
        p1_rdata    = '0;
        dmem_r_en   = 1'b0;
        dmem_w_en   = 1'b0;
        dmem_w_strb = '0;
        dmem_addr   = acc_addr;
        dmem_w_data = acc_wdata;

        case (state)
            ISSUE: begin
                dmem_r_en = !acc_we && !acc_oob;
                dmem_w_en = acc_we && !acc_oob;
                if (acc_we && !acc_oob) dmem_w_strb = acc_strb;
            end
            RESP: begin
                if (acc_owner) begin
                    p1_done = 1'b1;
                    p1_err  = acc_oob;
                    if (!acc_we && !acc_oob) p1_rdata = dmem_r_data;
                end else begin
                    p0_done = 1'b1;
                    if (!acc_we) p0_rdata = dmem_r_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_otter_mem_arb.sv
// Directed bench for otter_mem_arb with a word-addressed memory model behind the dmem port.
module tb_otter_mem_arb;

    localparam int unsigned MEM_SIZE = 65536;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we;
    logic [3:0]  p0_strb;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_done;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_we;
    logic [3:0]  p1_strb;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_done, p1_err;
    logic [31:0] p1_rdata;
    logic        dmem_r_en, dmem_w_en;
    logic [3:0]  dmem_w_strb;
    logic [31:0] dmem_addr, dmem_w_data;
    logic [31:0] dmem_r_data = '0;

    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    otter_mem_arb #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_strb(p0_strb), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_strb(p1_strb), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en), .dmem_w_strb(dmem_w_strb),
        .dmem_addr(dmem_addr), .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data)
    );

    always #5 clk = ~clk;

    // Memory model: byte-strobed writes, one-cycle registered reads.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (dmem_w_en)
            for (int b = 0; b < 4; b++)
                if (dmem_w_strb[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_w_data[8*b +: 8];
        if (dmem_r_en) dmem_r_data <= mem[dmem_addr[9:2]];
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_strb = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_strb = '0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p0_req = 1; p1_req = 1; p0_we = 1; p0_strb = 4'hF; p0_addr = 32'h44; p0_wdata = 32'h5A5A5A5A;
        preload(8'd64, 32'hDEADBEEF);
        preload(8'd8, 32'h11223344);
        #1;
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b%b want 00", p0_gnt, p1_gnt); end
        checks++; if ({p0_done, p1_done, p1_err} !== 3'b000) begin errors++; $display("FAIL rst_done got %b want 000", {p0_done, p1_done, p1_err}); end
        checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h want 0", p0_rdata, p1_rdata); end
        checks++; if ({dmem_r_en, dmem_w_en, dmem_w_strb} !== 6'b0) begin errors++; $display("FAIL rst_dmem_ctl got %b want 0", {dmem_r_en, dmem_w_en, dmem_w_strb}); end
        checks++; if (dmem_addr !== 32'h0 || dmem_w_data !== 32'h0) begin errors++; $display("FAIL rst_dmem_bus got %h %h want 0", dmem_addr, dmem_w_data); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 32'h100; #1;
        checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt got %b%b want 10", p0_gnt, p1_gnt); end
        @(negedge clk);
        p0_req = 0; p0_addr = 32'hFFFF0000; p0_we = 1; #1;
        checks++; if (dmem_r_en !== 1'b1 || dmem_w_en !== 1'b0 || dmem_w_strb !== 4'h0) begin errors++; $display("FAIL rd_issue got r%b w%b s%h want r1 w0 s0", dmem_r_en, dmem_w_en, dmem_w_strb); end
        checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h want 00000100", dmem_addr); end
        checks++; if (p0_done !== 1'b0) begin errors++; $display("FAIL rd_early_done got %b want 0", p0_done); end
        @(negedge clk); #1;
        checks++; if (p0_done !== 1'b1 || p1_done !== 1'b0) begin errors++; $display("FAIL rd_done got %b%b want 10", p0_done, p1_done); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", p0_rdata); end
        checks++; if (dmem_r_en !== 1'b0) begin errors++; $display("FAIL rd_resp_ren got %b want 0", dmem_r_en); end
        @(negedge clk); #1;
        checks++; if (p0_done !== 1'b0 || p0_rdata !== 32'h0) begin errors++; $display("FAIL rd_after got %b %h want 0 0", p0_done, p0_rdata); end
        checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr_hold got %h want 00000100", dmem_addr); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int unsigned g;
        logic exp_port;
        p0_req = 1; p0_we = 0; p0_addr = 32'h100;
        p1_req = 1; p1_we = 0; p1_addr = 32'h20;
        do_reset();
        g = 0;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            #1;
`ifdef OTTER_MEM_ARB_FIXED_PRIO_EN
            exp_port = 1'b0;
`else
            exp_port = g[0];
`endif
            if (c % 3 == 0) begin
                checks++; if (p0_gnt !== !exp_port || p1_gnt !== exp_port) begin errors++; $display("FAIL rr_grant%0d got %b%b want port %0d", g, p0_gnt, p1_gnt, exp_port); end
                g++;
            end else begin
                checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rr_busy_c%0d got %b%b want 00", c, p0_gnt, p1_gnt); end
            end
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_write_strobe();
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_strb = 4'b0010; p1_addr = 32'h20; p1_wdata = 32'h0000AB00; #1;
        checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b%b want 01", p0_gnt, p1_gnt); end
        @(negedge clk);
        p1_req = 0; p1_strb = 4'hF; p1_wdata = 32'hFFFFFFFF; #1;
        checks++; if (dmem_w_en !== 1'b1 || dmem_r_en !== 1'b0 || dmem_w_strb !== 4'b0010) begin errors++; $display("FAIL wr_issue got w%b r%b s%b want w1 r0 s0010", dmem_w_en, dmem_r_en, dmem_w_strb); end
        checks++; if (dmem_w_data !== 32'h0000AB00 || dmem_addr !== 32'h20) begin errors++; $display("FAIL wr_bus got %h @%h want 0000ab00 @20", dmem_w_data, dmem_addr); end
        @(negedge clk); #1;
        checks++; if (p1_done !== 1'b1 || p1_err !== 1'b0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL wr_done got d%b e%b %h want d1 e0 0", p1_done, p1_err, p1_rdata); end
        checks++; if (dmem_w_en !== 1'b0 || dmem_w_strb !== 4'h0) begin errors++; $display("FAIL wr_resp_ctl got w%b s%b want 0", dmem_w_en, dmem_w_strb); end
        // zero-strobe write: still issued, completes, leaves memory untouched
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_strb = 4'h0; p0_addr = 32'h20; p0_wdata = 32'hFFFFFFFF; #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL wr0_gnt got %b want 1", p0_gnt); end
        @(negedge clk);
        p0_req = 0; #1;
        checks++; if (dmem_w_en !== 1'b1 || dmem_w_strb !== 4'h0) begin errors++; $display("FAIL wr0_issue got w%b s%b want w1 s0", dmem_w_en, dmem_w_strb); end
        @(negedge clk); #1;
        checks++; if (p0_done !== 1'b1 || p0_rdata !== 32'h0) begin errors++; $display("FAIL wr0_done got %b %h want 1 0", p0_done, p0_rdata); end
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 32'h20; #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rb_gnt got %b want 1", p0_gnt); end
        @(negedge clk);
        p0_req = 0;
        @(negedge clk); #1;
        checks++; if (p0_done !== 1'b1 || p0_rdata !== 32'h1122AB44) begin errors++; $display("FAIL rb_data got %b %h want 1 1122ab44", p0_done, p0_rdata); end
        idle_inputs();
    endtask

    task automatic test_range();
        @(negedge clk);
        p1_req = 1; p1_we = 0; p1_addr = MEM_SIZE; #1;
        checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL oob_gnt got %b want 1", p1_gnt); end
        @(negedge clk);
        p1_req = 0; #1;
        checks++; if (dmem_r_en !== 1'b0 || dmem_w_en !== 1'b0) begin errors++; $display("FAIL oob_issue got r%b w%b want 00", dmem_r_en, dmem_w_en); end
        @(negedge clk); #1;
        checks++; if (p1_done !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'h0) begin errors++; $display("FAIL oob_resp got d%b e%b %h want d1 e1 0", p1_done, p1_err, p1_rdata); end
        @(negedge clk); #1;
        checks++; if (p1_err !== 1'b0 || p1_done !== 1'b0) begin errors++; $display("FAIL oob_after got d%b e%b want 00", p1_done, p1_err); end
        // last in-range word on port 1
        p1_req = 1; p1_we = 0; p1_addr = MEM_SIZE - 4;
        @(negedge clk);
        p1_req = 0; #1;
        checks++; if (dmem_r_en !== 1'b1) begin errors++; $display("FAIL edge_issue got r%b want 1", dmem_r_en); end
        @(negedge clk); #1;
        checks++; if (p1_done !== 1'b1 || p1_err !== 1'b0) begin errors++; $display("FAIL edge_resp got d%b e%b want d1 e0", p1_done, p1_err); end
        // port 0 beyond MEM_SIZE passes through
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = MEM_SIZE;
        @(negedge clk);
        p0_req = 0; #1;
        checks++; if (dmem_r_en !== 1'b1 || dmem_addr !== MEM_SIZE) begin errors++; $display("FAIL p0_pass got r%b @%h want r1 @%h", dmem_r_en, dmem_addr, MEM_SIZE); end
        @(negedge clk); #1;
        checks++; if (p0_done !== 1'b1) begin errors++; $display("FAIL p0_pass_done got %b want 1", p0_done); end
        idle_inputs();
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_strb = 4'hF; p0_addr = 32'h40; p0_wdata = 32'hCAFEF00D; #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL ab_gnt got %b want 1", p0_gnt); end
        @(negedge clk);
        p0_req = 0; #1;
        checks++; if (dmem_w_en !== 1'b1) begin errors++; $display("FAIL ab_issue got %b want 1", dmem_w_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dmem_w_en !== 1'b0 || dmem_w_strb !== 4'h0) begin errors++; $display("FAIL ab_async got w%b s%h want 0", dmem_w_en, dmem_w_strb); end
        checks++; if (dmem_addr !== 32'h0 || dmem_w_data !== 32'h0) begin errors++; $display("FAIL ab_bus got %h %h want 0", dmem_addr, dmem_w_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (p0_done !== 1'b0 || dmem_w_en !== 1'b0) begin errors++; $display("FAIL ab_nodone_c%0d got d%b w%b want 00", c, p0_done, dmem_w_en); end
            @(negedge clk);
        end
        p0_req = 1; p0_we = 0; p0_addr = 32'h100; #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL ab_regrant got %b want 1", p0_gnt); end
        @(negedge clk);
        p0_req = 0;
        @(negedge clk); #1;
        checks++; if (p0_done !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ab_read got %b %h want 1 deadbeef", p0_done, p0_rdata); end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_read();
        test_round_robin();
        test_write_strobe();
        test_range();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
